// File: rtl/draw_scheduler.sv
// Frame scheduler for the shared VGA pixel port: ERASE pass, one logic_go pulse, PAINT pass.
// Optional grant watchdog enabled by defining DRAW_SCHED_WDOG_EN (adds WDOG_CYCLES and wdog_fault).
module draw_scheduler #(
  parameter int N_REQ      = 3,
  parameter int LOGIC_WAIT = 10
`ifdef DRAW_SCHED_WDOG_EN
  , parameter int WDOG_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     last,
  input  logic [N_REQ-1:0]     px_en_i,
  input  logic [10*N_REQ-1:0]  px_x_i,
  input  logic [10*N_REQ-1:0]  px_y_i,
  input  logic [3*N_REQ-1:0]   px_col_i,
  output logic [N_REQ-1:0]     start,
  output logic [N_REQ-1:0]     grant,
  output logic                 iscolour,
  output logic                 logic_go,
  output logic [9:0]           x,
  output logic [9:0]           y,
  output logic [2:0]           colour,
  output logic                 writeEn,
  output logic                 busy,
  output logic                 overrun
`ifdef DRAW_SCHED_WDOG_EN
  , output logic               wdog_fault
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LW_W  = $clog2(LOGIC_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_E_SCAN, S_E_RUN, S_LOGIC, S_P_SCAN, S_P_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               drain_q, drain_d;
  logic [LW_W-1:0]    lcnt_q, lcnt_d;
  logic [N_REQ-1:0]   start_q, start_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               iscolour_q, iscolour_d;
  logic               logic_go_q, logic_go_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [2:0]         colour_q, colour_d;
  logic               wr_q, wr_d;
  logic               overrun_q, overrun_d;
`ifdef DRAW_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic               wdog_q, wdog_d;
`endif

  logic [9:0]         slot_x   [N_REQ];
  logic [9:0]         slot_y   [N_REQ];
  logic [2:0]         slot_col [N_REQ];
  logic [N_REQ-1:0]   idx_oh;
  logic               idx_last;
  logic               erase_pass;
  logic               pass_end;
  logic               timeout;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign slot_x[gi]   = px_x_i[10*gi +: 10];
    assign slot_y[gi]   = px_y_i[10*gi +: 10];
    assign slot_col[gi] = px_col_i[3*gi +: 3];
  end

  always_comb begin
    idx_oh = '0;
    idx_oh[idx_q] = 1'b1;
  end

  assign idx_last   = (idx_q == IDX_W'(N_REQ - 1));
  assign erase_pass = (state_q == S_E_SCAN) || (state_q == S_E_RUN);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    lcnt_d     = lcnt_q;
    start_d    = '0;
    grant_d    = grant_q;
    iscolour_d = iscolour_q;
    logic_go_d = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    wr_d       = 1'b0;
    overrun_d  = overrun_q | (frame_tick & (state_q != S_IDLE));
    pass_end   = 1'b0;
    timeout    = 1'b0;
`ifdef DRAW_SCHED_WDOG_EN
    wd_cnt_d   = wd_cnt_q;
    wdog_d     = wdog_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d    = S_E_SCAN;
          idx_d      = '0;
          iscolour_d = 1'b0;
        end
      end
      S_E_SCAN, S_P_SCAN: begin
        if (req[idx_q]) begin
          start_d = idx_oh;
          grant_d = idx_oh;
          drain_d = 1'b0;
          state_d = erase_pass ? S_E_RUN : S_P_RUN;
`ifdef DRAW_SCHED_WDOG_EN
          wd_cnt_d = '0;
`endif
        end else if (idx_last) begin
          pass_end = 1'b1;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      S_E_RUN, S_P_RUN: begin
        // One extra granted cycle after last lets the final pixel leave the output register.
        if (drain_q) begin
          grant_d = '0;
          drain_d = 1'b0;
          if (idx_last) begin
            pass_end = 1'b1;
          end else begin
            idx_d   = IDX_W'(idx_q + 1'b1);
            state_d = erase_pass ? S_E_SCAN : S_P_SCAN;
          end
        end else begin
          wr_d = px_en_i[idx_q];
          if (px_en_i[idx_q]) begin
            x_d      = slot_x[idx_q];
            y_d      = slot_y[idx_q];
            colour_d = iscolour_q ? slot_col[idx_q] : 3'b000;
          end
`ifdef DRAW_SCHED_WDOG_EN
          wd_cnt_d = WD_W'(wd_cnt_q + 1'b1);
          timeout  = !last[idx_q] && (wd_cnt_q == WD_W'(WDOG_CYCLES - 2));
          if (timeout) wdog_d = 1'b1;
`endif
          if (last[idx_q] || timeout) drain_d = 1'b1;
        end
      end
      S_LOGIC: begin
        if (lcnt_q == LW_W'(LOGIC_WAIT - 1)) begin
          state_d    = S_P_SCAN;
          iscolour_d = 1'b1;
          idx_d      = '0;
        end else begin
          lcnt_d = LW_W'(lcnt_q + 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pass_end) begin
      if (erase_pass) begin
        state_d    = S_LOGIC;
        logic_go_d = 1'b1;
        lcnt_d     = '0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      drain_q    <= 1'b0;
      lcnt_q     <= '0;
      start_q    <= '0;
      grant_q    <= '0;
      iscolour_q <= 1'b0;
      logic_go_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      wr_q       <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef DRAW_SCHED_WDOG_EN
      wd_cnt_q   <= '0;
      wdog_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      lcnt_q     <= lcnt_d;
      start_q    <= start_d;
      grant_q    <= grant_d;
      iscolour_q <= iscolour_d;
      logic_go_q <= logic_go_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      wr_q       <= wr_d;
      overrun_q  <= overrun_d;
`ifdef DRAW_SCHED_WDOG_EN
      wd_cnt_q   <= wd_cnt_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign start    = start_q;
  assign grant    = grant_q;
  assign iscolour = iscolour_q;
  assign logic_go = logic_go_q;
  assign x        = x_q;
  assign y        = y_q;
  assign colour   = colour_q;
  assign writeEn  = wr_q;
  assign busy     = (state_q != S_IDLE);
  assign overrun  = overrun_q;
`ifdef DRAW_SCHED_WDOG_EN
  assign wdog_fault = wdog_q;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// Randomized bench for draw_scheduler: behavioural sprite engines plus a frame-level reference model.
module tb_draw_scheduler;

  localparam int N = 3;
  localparam int LW = 10;
`ifdef DRAW_SCHED_WDOG_EN
  localparam int WD = 16;
  localparam int CAP = WD - 1;
`else
  localparam int CAP = 1 << 20;
`endif

  logic clk = 1'b0;
  logic reset, frame_tick;
  logic [N-1:0] req, last, px_en_i;
  logic [10*N-1:0] px_x_i, px_y_i;
  logic [3*N-1:0] px_col_i;
  logic [N-1:0] start, grant;
  logic iscolour, logic_go, writeEn, busy, overrun;
  logic [9:0] x, y;
  logic [2:0] colour;
`ifdef DRAW_SCHED_WDOG_EN
  logic wdog_fault;
`endif

  always #5 clk = ~clk;

  draw_scheduler #(
    .N_REQ(N), .LOGIC_WAIT(LW)
`ifdef DRAW_SCHED_WDOG_EN
    , .WDOG_CYCLES(WD)
`endif
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .req(req), .last(last),
    .px_en_i(px_en_i), .px_x_i(px_x_i), .px_y_i(px_y_i), .px_col_i(px_col_i),
    .start(start), .grant(grant), .iscolour(iscolour), .logic_go(logic_go),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy), .overrun(overrun)
`ifdef DRAW_SCHED_WDOG_EN
    , .wdog_fault(wdog_fault)
`endif
  );

  typedef struct packed { logic [9:0] px; logic [9:0] py; logic [2:0] pc; } pix_t;

  int checks = 0;
  int failures = 0;

  // engine configuration and state
  int         e_len [N];
  logic [2:0] e_col [N];
  logic [9:0] e_bx  [N];
  logic [9:0] e_by  [N];
  int         e_k   [N];
  bit         e_act [N];

  // observations of one frame
  pix_t obs_wr[$];
  int   obs_gnt[$];
  int   obs_starts[N];
  int   obs_gcyc[N];
  int   obs_lg, obs_lg_cyc, obs_lg_pos, obs_busy, obs_onehot_bad, obs_wr_nogrant;
  bit   obs_timeout, rst_hit;
  logic [N-1:0] rst_g;
  logic rst_we, rst_busy;

  // reference model of one frame
  pix_t exp_wr[$];
  int   exp_gnt[$];
  int   exp_pass_e, exp_busy, exp_erase_wr;

  task automatic build_model(input logic [N-1:0] rq);
    int eff;
    exp_wr.delete();
    exp_gnt.delete();
    exp_pass_e = N;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++)
        if (rq[i]) begin
          eff = (e_len[i] < CAP) ? e_len[i] : CAP;
          exp_gnt.push_back(i);
          if (p == 0) exp_pass_e += eff + 1;
          for (int k = 0; k < eff; k++)
            exp_wr.push_back('{px: 10'(int'(e_bx[i]) + k), py: e_by[i], pc: (p == 0) ? 3'b000 : e_col[i]});
        end
    exp_erase_wr = exp_wr.size() / 2;
    exp_busy = 2 * exp_pass_e + LW;
  endtask

  task automatic randomize_engines(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      e_len[i] = $urandom_range(hi, lo);
      e_col[i] = 3'($urandom_range(7, 1));
      e_bx[i]  = 10'($urandom_range(600, 0));
      e_by[i]  = 10'($urandom_range(450, 0));
    end
  endtask

  task automatic drive_engines();
    for (int i = 0; i < N; i++) begin
      if (start[i]) begin e_act[i] = 1'b1; e_k[i] = 0; end
      if (e_act[i] && !grant[i]) e_act[i] = 1'b0;
      if (e_act[i]) begin
        px_en_i[i] = 1'b1;
        px_x_i[i*10 +: 10] = 10'(int'(e_bx[i]) + e_k[i]);
        px_y_i[i*10 +: 10] = e_by[i];
        px_col_i[i*3 +: 3] = e_col[i];
        last[i] = (e_k[i] == e_len[i] - 1);
        e_k[i]++;
        if (e_k[i] >= e_len[i]) e_act[i] = 1'b0;
      end else begin
        // idle slots chatter to prove non-granted inputs are ignored
        px_en_i[i] = grant[i] ? 1'b0 : 1'($urandom_range(1, 0));
        px_x_i[i*10 +: 10] = 10'($urandom);
        px_y_i[i*10 +: 10] = 10'($urandom);
        px_col_i[i*3 +: 3] = 3'($urandom);
        last[i] = grant[i] ? 1'b0 : ($urandom_range(3, 0) == 0);
      end
    end
  endtask

  task automatic quiet_inputs();
    px_en_i = '0; last = '0; px_x_i = '0; px_y_i = '0; px_col_i = '0;
    for (int i = 0; i < N; i++) e_act[i] = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [N-1:0] rq, input int tick2_at, input bit do_rst);
    logic [N-1:0] prev_g;
    int paint_g;
    obs_wr.delete(); obs_gnt.delete();
    for (int i = 0; i < N; i++) begin obs_starts[i] = 0; obs_gcyc[i] = 0; end
    obs_lg = 0; obs_lg_cyc = -1; obs_lg_pos = -1; obs_busy = 0;
    obs_onehot_bad = 0; obs_wr_nogrant = 0; obs_timeout = 1'b1; rst_hit = 1'b0;
    prev_g = '0; paint_g = 0;
    req = rq;
    @(negedge clk);
    frame_tick = 1'b1;
    drive_engines();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (!busy) begin obs_timeout = 1'b0; break; end
      obs_busy++;
      for (int i = 0; i < N; i++) begin
        if (start[i]) obs_starts[i]++;
        if (grant[i]) obs_gcyc[i]++;
      end
      if ($countones(grant) > 1) obs_onehot_bad++;
      if (grant != '0 && grant != prev_g)
        for (int i = 0; i < N; i++) if (grant[i]) obs_gnt.push_back(i);
      prev_g = grant;
      if (logic_go) begin obs_lg++; obs_lg_cyc = cyc; obs_lg_pos = obs_wr.size(); end
      if (writeEn) begin
        obs_wr.push_back('{px: x, py: y, pc: colour});
        if (grant == '0) obs_wr_nogrant++;
      end
      if (do_rst && iscolour && grant != '0) begin
        paint_g++;
        if (paint_g == 3) begin
          reset = 1'b1;
          #1;
          rst_g = grant; rst_we = writeEn; rst_busy = busy; rst_hit = 1'b1;
          quiet_inputs();
          req = '0;
          repeat (2) @(negedge clk);
          reset = 1'b0;
          obs_timeout = 1'b0;
          break;
        end
      end
      if (cyc == tick2_at) frame_tick = 1'b1;
      drive_engines();
    end
    frame_tick = 1'b0;
    quiet_inputs();
    if (obs_timeout) begin failures++; $display("FAIL %s frame_timeout busy=%0d required<=3000", name, obs_busy); end
    checks++;
    $display("frame %s req=%b writes=%0d busy_cycles=%0d logic_go=%0d grants=%0d", name, rq, obs_wr.size(), obs_busy, obs_lg, obs_gnt.size());
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 1'b0; req = '0; quiet_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (grant !== '0)      begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (start !== '0)      begin failures++; $display("FAIL reset_start got=%b exp=000", start); end
    checks++; if (writeEn !== 1'b0)  begin failures++; $display("FAIL reset_writeEn got=%b exp=0", writeEn); end
    checks++; if (overrun !== 1'b0)  begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (logic_go !== 1'b0) begin failures++; $display("FAIL reset_logic_go got=%b exp=0", logic_go); end
    checks++; if (iscolour !== 1'b0) begin failures++; $display("FAIL reset_iscolour got=%b exp=0", iscolour); end
    checks++; if ({x, y, colour} !== 23'd0) begin failures++; $display("FAIL reset_pixel got=%h exp=0", {x, y, colour}); end
`ifdef DRAW_SCHED_WDOG_EN
    checks++; if (wdog_fault !== 1'b0) begin failures++; $display("FAIL reset_wdog got=%b exp=0", wdog_fault); end
`endif
  endtask

  task automatic compare_frame(input string name);
    checks++; if (obs_wr.size() != exp_wr.size()) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", name, obs_wr.size(), exp_wr.size()); end
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (obs_wr[i] !== exp_wr[i]) begin
        failures++;
        $display("FAIL %s write[%0d] got x=%0d y=%0d c=%0d exp x=%0d y=%0d c=%0d", name, i,
                 obs_wr[i].px, obs_wr[i].py, obs_wr[i].pc, exp_wr[i].px, exp_wr[i].py, exp_wr[i].pc);
      end
    end
    checks++; if (obs_gnt != exp_gnt) begin failures++; $display("FAIL %s grant_order got=%p exp=%p", name, obs_gnt, exp_gnt); end
    checks++; if (obs_lg != 1) begin failures++; $display("FAIL %s logic_go_count got=%0d exp=1", name, obs_lg); end
    checks++; if (obs_lg_pos != exp_erase_wr) begin failures++; $display("FAIL %s logic_go_pos got=%0d exp=%0d", name, obs_lg_pos, exp_erase_wr); end
    checks++; if (obs_lg_cyc != exp_pass_e) begin failures++; $display("FAIL %s logic_go_cycle got=%0d exp=%0d", name, obs_lg_cyc, exp_pass_e); end
    checks++; if (obs_busy != exp_busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, obs_busy, exp_busy); end
    checks++; if (obs_onehot_bad != 0) begin failures++; $display("FAIL %s grant_onehot got=%0d exp=0", name, obs_onehot_bad); end
    checks++; if (obs_wr_nogrant != 0) begin failures++; $display("FAIL %s write_without_grant got=%0d exp=0", name, obs_wr_nogrant); end
  endtask

  task automatic test_ball_only();
    randomize_engines(4, 4);
    build_model(3'b001);
    run_frame("ball_only", 3'b001, -1, 1'b0);
    compare_frame("ball_only");
    checks++; if (obs_starts[0] != 2) begin failures++; $display("FAIL ball_starts got=%0d exp=2", obs_starts[0]); end
  endtask

  task automatic test_all_slots();
    randomize_engines(1, 1);
    e_len[0] = 30; e_len[1] = 32; e_len[2] = 10;
    build_model(3'b111);
    run_frame("all_slots", 3'b111, -1, 1'b0);
    compare_frame("all_slots");
  endtask

  task automatic test_random_frames();
    logic [N-1:0] rq;
    for (int f = 0; f < 6; f++) begin
      randomize_engines(1, 14);
      rq = 3'($urandom_range(7, 1));
      build_model(rq);
      run_frame("random", rq, -1, 1'b0);
      compare_frame("random");
    end
  endtask

  task automatic test_idle_frame();
    build_model(3'b000);
    run_frame("idle", 3'b000, -1, 1'b0);
    compare_frame("idle");
    checks++; if (obs_lg_cyc != 3) begin failures++; $display("FAIL idle_logic_go_cycle got=%0d exp=3", obs_lg_cyc); end
    checks++; if (obs_busy != LW + 6) begin failures++; $display("FAIL idle_busy got=%0d exp=%0d", obs_busy, LW + 6); end
  endtask

  task automatic test_overrun();
    int extra;
    randomize_engines(8, 12);
    build_model(3'b111);
    run_frame("overrun", 3'b111, 5, 1'b0);
    compare_frame("overrun");
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
    extra = 0;
    repeat (30) begin @(negedge clk); if (busy) extra++; end
    checks++; if (extra != 0) begin failures++; $display("FAIL overrun_extra_frame busy_cycles got=%0d exp=0", extra); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
  endtask

  task automatic test_reset_burst();
    randomize_engines(6, 6);
    run_frame("reset_burst", 3'b011, -1, 1'b1);
    checks++; if (!rst_hit) begin failures++; $display("FAIL rst_reached got=0 exp=1"); end
    checks++; if (rst_g !== '0) begin failures++; $display("FAIL rst_grant got=%b exp=000", rst_g); end
    checks++; if (rst_we !== 1'b0) begin failures++; $display("FAIL rst_writeEn got=%b exp=0", rst_we); end
    checks++; if (rst_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", rst_busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
    randomize_engines(2, 9);
    build_model(3'b011);
    run_frame("after_reset", 3'b011, -1, 1'b0);
    compare_frame("after_reset");
  endtask

`ifdef DRAW_SCHED_WDOG_EN
  task automatic test_watchdog();
    randomize_engines(4, 4);
    e_len[1] = 1000;
    build_model(3'b111);
    run_frame("watchdog", 3'b111, -1, 1'b0);
    compare_frame("watchdog");
    checks++; if (wdog_fault !== 1'b1) begin failures++; $display("FAIL wdog_fault got=%b exp=1", wdog_fault); end
    checks++; if (obs_gcyc[1] != 2 * WD) begin failures++; $display("FAIL wdog_grant_cycles got=%0d exp=%0d", obs_gcyc[1], 2 * WD); end
  endtask
`endif

  initial begin
    test_reset();
    test_ball_only();
    test_all_slots();
    test_random_frames();
    test_idle_frame();
    test_overrun();
    test_reset_burst();
`ifdef DRAW_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
